// File: rtl/uart_pkg.sv
// uart_pkg: shared UART transmitter types and constants
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  localparam int DEFAULT_CLKS_PER_BIT = 5208;
  localparam int DATA_BITS = 8;
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter with a tick on the last cycle of each bit
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick,
  output logic pre_tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  localparam logic [W-1:0] PRE = W'(CLKS_PER_BIT - 2);
  logic [W-1:0] cnt;
  assign bit_tick = cnt == LAST;
  // pre_tick lets the caller register an output that lands on the last cycle of a bit
  assign pre_tick = cnt == PRE;
  always_ff @(posedge clk) begin
    if (rst || clear || bit_tick) cnt <= '0;
    else cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: 8N1 UART transmitter triggered by a rising edge on tx_start
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);
  tx_state_t state;
  logic prev, start_pulse, clear, bit_tick, pre_tick;
  logic [DATA_BITS-1:0] shift_reg;
  logic [2:0] bit_cnt;
  assign start_pulse = tx_start & ~prev;
  assign clear = state == IDLE && start_pulse;
  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk(clk),
    .rst(rst),
    .clear(clear),
    .bit_tick(bit_tick),
    .pre_tick(pre_tick)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tx <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
      shift_reg <= '0;
      bit_cnt <= '0;
      prev <= 1'b0;
    end else begin
      prev <= tx_start;
      tx_done <= 1'b0;
      case (state)
        IDLE: if (start_pulse) begin
          shift_reg <= tx_data;
          bit_cnt <= '0;
          tx <= 1'b0;
          tx_busy <= 1'b1;
          state <= START;
        end
        START: if (bit_tick) begin
          tx <= shift_reg[0];
          state <= DATA;
        end
        DATA: if (bit_tick) begin
          shift_reg <= shift_reg >> 1;
          bit_cnt <= bit_cnt + 3'd1;
          tx <= bit_cnt == 3'd7 ? 1'b1 : shift_reg[1];
          state <= bit_cnt == 3'd7 ? STOP : DATA;
        end
        STOP: begin
          tx_done <= pre_tick;
          if (bit_tick) begin
            tx_busy <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter CLKS_PER_BIT, default 5208, clock cycles per serial bit (50 MHz / 9600 baud); legal range 2..65535.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 tx_start  input  1  level request; a 0->1 transition requests one frame.
REQ-005 tx_data  input  8  byte to send; sampled only on the accepting cycle.
REQ-006 tx  output  1  serial line, idle high.
REQ-007 tx_busy  output  1  high while a frame is in progress.
REQ-008 tx_done  output  1  one-cycle pulse at frame completion.

Function
REQ-009 Edge detection: the block SHALL register tx_start each cycle (prev) and form start_pulse = tx_start & ~prev.
REQ-010 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-011 IDLE: tx=1, tx_busy=0; on start_pulse, latch tx_data into an 8-bit shift register, clear bit/baud counters, go to START.
REQ-012 start_pulse SHALL be accepted only in IDLE; pulses in any other state are discarded, not queued.
REQ-013 Latency: if start_pulse is high in cycle N, tx SHALL be 0 and tx_busy 1 from cycle N+1.
REQ-014 START: tx=0 for exactly CLKS_PER_BIT cycles, then DATA.
REQ-015 DATA: tx = shift_reg[0]; each bit held CLKS_PER_BIT cycles; shift right after each bit; 8 bits, LSB first, then STOP.
REQ-016 STOP: tx=1 for CLKS_PER_BIT cycles; in the last STOP cycle tx_done=1, and the next state is IDLE.
REQ-017 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles from the first START cycle to the last STOP cycle inclusive.
REQ-018 tx_busy SHALL be high in START, DATA, and STOP, including the tx_done cycle.
REQ-019 A start_pulse coincident with tx_done SHALL be ignored; a 0->1 edge in the following cycle or later SHALL be accepted.
REQ-020 tx_start held high SHALL produce exactly one frame; a new frame requires a return to 0.
REQ-021 Changes to tx_data after acceptance SHALL NOT affect the frame in flight.
REQ-022 The baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide, count 0..CLKS_PER_BIT-1, and wrap to 0 at each bit boundary.
REQ-023 The bit counter SHALL be 3 bits wide, count 0..7 in DATA, and wrap to 0 on entry to STOP.

Reset
REQ-024 While rst=1 at a clock edge, the following SHALL hold the next cycle: state=IDLE, tx=1, tx_busy=0, tx_done=0, counters=0, shift register=0, prev=0.
REQ-025 Reset mid-frame SHALL abort the frame immediately, with tx high the cycle after the rst edge and no tx_done.
REQ-026 Because prev resets to 0, tx_start high in the first cycle after reset release SHALL be treated as an edge and start a frame.

Structure
REQ-027 Shared package uart_pkg SHALL hold the FSM state enum (tx_state_t), DEFAULT_CLKS_PER_BIT=5208, and DATA_BITS=8.
REQ-028 The baud timing SHALL be one sub-module, uart_baud_gen (counter, clear input, one-cycle bit_tick output), instantiated once.
REQ-029 tx SHALL be driven from a flop (registered output, glitch-free).

Verification (CLKS_PER_BIT=4)
REQ-030 Basic frame: rst released, tx_data=8'hA5, tx_start 0->1 at cycle 10 -> tx over cycles 11..50 = 0,1,0,1,0,0,1,0,1,1 per 4-cycle bit; tx_done=1 at cycle 50 only; tx_busy 11..50.
REQ-031 Held level: tx_start held high for 200 cycles -> exactly one frame, one tx_done.
REQ-032 Busy retrigger: new 0->1 edge at cycle 30 of the A5 frame with tx_data=8'h3C -> ignored; line carries A5 only.
REQ-033 Back-to-back: edge on the tx_done cycle -> ignored; edge one cycle later with 8'hFF -> new START the following cycle.
REQ-034 Reset mid-frame: rst pulsed during DATA bit 3 -> tx=1, tx_busy=0 the next cycle; no tx_done; a subsequent 8'h00 frame is correct.
REQ-035 Data stability: tx_data toggled randomly after acceptance of 8'h5A -> 5A transmitted unchanged.
